// File: rtl/top_design_sel_pkg.sv
// Shared definitions for the design-mux selection driver: sequencer states,
// register offsets and CTRL readback bit positions.
package top_design_sel_pkg;

  localparam int ID_W = 4;

  localparam logic [31:0] CTRL_OFF   = 32'h0000_0000;
  localparam logic [31:0] STATUS_OFF = 32'h0000_0004;

  localparam int CTRL_BUSY_BIT = 4;
  localparam int CTRL_PEND_BIT = 5;

  typedef enum logic [2:0] {
    ST_BOOT,
    ST_IDLE,
    ST_SETUP,
    ST_HIGH,
    ST_HOLD
  } sel_state_e;

endpackage

// File: rtl/top_design_sel_ctrl_if.sv
// Wishbone slave bus used by the selection driver; the firmware side is the master.
interface top_design_sel_ctrl_if;

  logic        wbs_cyc_i;
  logic        wbs_stb_i;
  logic        wbs_we_i;
  logic [3:0]  wbs_sel_i;
  logic [31:0] wbs_adr_i;
  logic [31:0] wbs_dat_i;
  logic        wbs_ack_o;
  logic [31:0] wbs_dat_o;

  modport slave (
    input  wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
    output wbs_ack_o, wbs_dat_o
  );

  modport master (
    output wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
    input  wbs_ack_o, wbs_dat_o
  );

endinterface

// File: rtl/sel_wb_regs.sv
// Wishbone decode, single-cycle ack, one-deep pending request slot and
// CTRL/STATUS readback for the selection driver.
module sel_wb_regs
  import top_design_sel_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h3000_0000
) (
  input  logic                 wb_clk_i,
  input  logic                 rst_n,
  top_design_sel_ctrl_if.slave wbs,
  input  logic                 busy,
  input  logic [ID_W-1:0]      committed_id,
  input  logic [15:0]          commit_cnt,
  input  logic                 take_q,
  input  logic                 take_fwd,
  output logic                 pend_valid_q,
  output logic [ID_W-1:0]      pend_id_q,
  output logic                 pend_valid_fwd,
  output logic [ID_W-1:0]      pend_id_fwd
);

  logic            ack_q, ack_d;
  logic [31:0]     dat_q, dat_d;
  logic            pend_valid_d;
  logic [ID_W-1:0] pend_id_d;
  logic            ctrl_sel, status_sel, hit, ctrl_wr;
  logic [31:0]     ctrl_rd;
  logic            unused_wb_bits;

  assign ctrl_sel   = (wbs.wbs_adr_i == BASE_ADDR + CTRL_OFF);
  assign status_sel = (wbs.wbs_adr_i == BASE_ADDR + STATUS_OFF);
  // A live ack blocks a new hit, so acks are never back-to-back.
  assign hit     = wbs.wbs_cyc_i && wbs.wbs_stb_i && (ctrl_sel || status_sel) && !ack_q;
  assign ctrl_wr = hit && wbs.wbs_we_i && ctrl_sel && wbs.wbs_sel_i[0];

  // The forwarded view lets a write landing as HOLD ends launch without an IDLE cycle.
  assign pend_valid_fwd = pend_valid_q || ctrl_wr;
  assign pend_id_fwd    = ctrl_wr ? wbs.wbs_dat_i[ID_W-1:0] : pend_id_q;

  assign unused_wb_bits = ^{wbs.wbs_sel_i[3:1], wbs.wbs_dat_i[31:ID_W]};

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path infers a latch.
    ctrl_rd                = '0;
    ctrl_rd[ID_W-1:0]      = committed_id;
    ctrl_rd[CTRL_BUSY_BIT] = busy;
    ctrl_rd[CTRL_PEND_BIT] = pend_valid_q;

    ack_d = hit;
    dat_d = '0;
    if (hit && !wbs.wbs_we_i) begin
      dat_d = ctrl_sel ? ctrl_rd : {16'b0, commit_cnt};
    end

    pend_id_d    = pend_id_q;
    pend_valid_d = pend_valid_q && !(take_q || take_fwd);
    if (ctrl_wr) begin
      pend_id_d    = wbs.wbs_dat_i[ID_W-1:0];
      pend_valid_d = !take_fwd;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
  always_ff @(posedge wb_clk_i or negedge rst_n) begin
    if (!rst_n) begin
      ack_q        <= 1'b0;
      dat_q        <= '0;
      pend_valid_q <= 1'b0;
      pend_id_q    <= '0;
    end else begin
      ack_q        <= ack_d;
      dat_q        <= dat_d;
      pend_valid_q <= pend_valid_d;
      pend_id_q    <= pend_id_d;
    end
  end

  assign wbs.wbs_ack_o = ack_q;
  assign wbs.wbs_dat_o = dat_q;

endmodule

// File: rtl/top_design_sel_ctrl.sv
// Driver for the design-mux selection strobe: sequences sel_id setup, sel_clk
// high and hold phases, auto-selecting DEFAULT_ID after reset.
module top_design_sel_ctrl
  import top_design_sel_pkg::*;
#(
  parameter logic [31:0]     BASE_ADDR  = 32'h3000_0000,
  parameter logic [ID_W-1:0] DEFAULT_ID = 4'd0,
  parameter int              SETUP_CYC  = 2,
  parameter int              HIGH_CYC   = 2,
  parameter int              HOLD_CYC   = 2
) (
  input  logic                 wb_clk_i,
  input  logic                 rst_n,
  top_design_sel_ctrl_if.slave wbs,
  output logic                 sel_clk,
  output logic [ID_W-1:0]      sel_id,
  output logic                 busy
);

  localparam logic [7:0] SETUP_LD = 8'(SETUP_CYC - 1);
  localparam logic [7:0] HIGH_LD  = 8'(HIGH_CYC - 1);
  localparam logic [7:0] HOLD_LD  = 8'(HOLD_CYC - 1);

  sel_state_e      state_q, state_d;
  logic [7:0]      cnt_q, cnt_d;
  logic            sel_clk_q, sel_clk_d;
  logic [ID_W-1:0] sel_id_q, sel_id_d;
  logic [ID_W-1:0] committed_q, committed_d;
  logic [15:0]     commit_cnt_q, commit_cnt_d;
  logic            busy_q, busy_d;
  logic            take_q, take_fwd;
  logic            pend_valid_q, pend_valid_fwd;
  logic [ID_W-1:0] pend_id_q, pend_id_fwd;

  sel_wb_regs #(.BASE_ADDR(BASE_ADDR)) u_regs (
    .wb_clk_i      (wb_clk_i),
    .rst_n         (rst_n),
    .wbs           (wbs),
    .busy          (busy_q),
    .committed_id  (committed_q),
    .commit_cnt    (commit_cnt_q),
    .take_q        (take_q),
    .take_fwd      (take_fwd),
    .pend_valid_q  (pend_valid_q),
    .pend_id_q     (pend_id_q),
    .pend_valid_fwd(pend_valid_fwd),
    .pend_id_fwd   (pend_id_fwd)
  );

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    sel_clk_d    = sel_clk_q;
    sel_id_d     = sel_id_q;
    committed_d  = committed_q;
    commit_cnt_d = commit_cnt_q;
    take_q       = 1'b0;
    take_fwd     = 1'b0;

    unique case (state_q)
      ST_BOOT: begin
        sel_id_d = DEFAULT_ID;
        cnt_d    = SETUP_LD;
        state_d  = ST_SETUP;
      end
      ST_IDLE: begin
        if (pend_valid_q) begin
          sel_id_d = pend_id_q;
          take_q   = 1'b1;
          cnt_d    = SETUP_LD;
          state_d  = ST_SETUP;
        end
      end
      ST_SETUP: begin
        if (cnt_q == 8'd0) begin
          sel_clk_d = 1'b1;
          cnt_d     = HIGH_LD;
          state_d   = ST_HIGH;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      ST_HIGH: begin
        if (cnt_q == 8'd0) begin
          sel_clk_d   = 1'b0;
          committed_d = sel_id_q;
          cnt_d       = HOLD_LD;
          state_d     = ST_HOLD;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      ST_HOLD: begin
        if (cnt_q == 8'd0) begin
          commit_cnt_d = commit_cnt_q + 16'd1;
          if (pend_valid_fwd) begin
            sel_id_d = pend_id_fwd;
            take_fwd = 1'b1;
            cnt_d    = SETUP_LD;
            state_d  = ST_SETUP;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      default: state_d = ST_BOOT;
    endcase

    // Registered from next state so busy reads 0 in reset and rises with the first sequence.
    busy_d = (state_d != ST_IDLE);
  end

  // NOTE: every control flop is reset asynchronously; reset aborts a sequence mid-strobe.
  always_ff @(posedge wb_clk_i or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_BOOT;
      cnt_q        <= '0;
      sel_clk_q    <= 1'b0;
      sel_id_q     <= '0;
      committed_q  <= '0;
      commit_cnt_q <= '0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      sel_clk_q    <= sel_clk_d;
      sel_id_q     <= sel_id_d;
      committed_q  <= committed_d;
      commit_cnt_q <= commit_cnt_d;
      busy_q       <= busy_d;
    end
  end

  assign sel_clk = sel_clk_q;
  assign sel_id  = sel_id_q;
  assign busy    = busy_q;

endmodule

// File: tb/tb_top_design_sel_ctrl.sv
// Directed bench for top_design_sel_ctrl with a capture scoreboard modelling
// top_design_mux sampling sel_id on each sel_clk rising edge.
module tb_top_design_sel_ctrl;

  localparam logic [31:0] BASE  = 32'h3000_0000;
  localparam logic [3:0]  DEF_ID = 4'd9;
  localparam int          SETUP = 2;
  localparam int          HIGH  = 3;
  localparam int          HOLD  = 2;

  logic       wb_clk_i = 1'b0;
  logic       rst_n;
  logic       sel_clk;
  logic [3:0] sel_id;
  logic       busy;

  int n_checks = 0;
  int n_fail   = 0;
  int viol     = 0;
  logic [3:0] cap_q[$];
  logic [3:0] exp_q[$];

  top_design_sel_ctrl_if bus ();

  top_design_sel_ctrl #(
    .BASE_ADDR (BASE),
    .DEFAULT_ID(DEF_ID),
    .SETUP_CYC (SETUP),
    .HIGH_CYC  (HIGH),
    .HOLD_CYC  (HOLD)
  ) dut (
    .wb_clk_i(wb_clk_i),
    .rst_n   (rst_n),
    .wbs     (bus),
    .sel_clk (sel_clk),
    .sel_id  (sel_id),
    .busy    (busy)
  );

  always #5 wb_clk_i = ~wb_clk_i;

  // Mux model: capture on sel_clk rise; id must not move while the strobe is high.
  always @(posedge sel_clk) cap_q.push_back(sel_id);
  always @(negedge sel_clk) begin
    if (rst_n && cap_q.size() > 0 && sel_id !== cap_q[$]) viol++;
  end

  task automatic wb_xfer(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                         input logic [3:0] sel, output logic [31:0] rdata, output int waits);
    @(negedge wb_clk_i);
    bus.wbs_cyc_i = 1'b1;
    bus.wbs_stb_i = 1'b1;
    bus.wbs_we_i  = we;
    bus.wbs_adr_i = adr;
    bus.wbs_dat_i = dat;
    bus.wbs_sel_i = sel;
    waits = -1;
    rdata = '0;
    for (int i = 1; i <= 8; i++) begin
      @(negedge wb_clk_i);
      if (bus.wbs_ack_o) begin
        waits = i;
        rdata = bus.wbs_dat_o;
        break;
      end
    end
    bus.wbs_cyc_i = 1'b0;
    bus.wbs_stb_i = 1'b0;
    bus.wbs_we_i  = 1'b0;
  endtask

  task automatic cycles_to_rise(output int n);
    n = -1;
    for (int i = 1; i <= 50; i++) begin
      @(negedge wb_clk_i);
      if (sel_clk) begin
        n = i;
        break;
      end
    end
  endtask

  task automatic wait_idle(output logic ok);
    ok = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(negedge wb_clk_i);
      if (!busy) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset;
    logic [31:0] rd;
    int w, n;
    logic ok;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({sel_clk, sel_id, busy, bus.wbs_ack_o, bus.wbs_dat_o} !== 39'b0) begin
      n_fail++;
      $display("FAIL reset_outputs: got clk=%b id=%h busy=%b ack=%b dat=%h, want all zero",
               sel_clk, sel_id, busy, bus.wbs_ack_o, bus.wbs_dat_o);
    end
    repeat (2) @(negedge wb_clk_i);
    rst_n = 1'b1;
    @(negedge wb_clk_i);
    n_checks++;
    if (sel_id !== DEF_ID || busy !== 1'b1 || sel_clk !== 1'b0) begin
      n_fail++;
      $display("FAIL boot_load: got id=%h busy=%b clk=%b, want id=%h busy=1 clk=0",
               sel_id, busy, sel_clk, DEF_ID);
    end
    cycles_to_rise(n);
    n_checks++;
    if (n + 1 !== SETUP + 1) begin
      n_fail++;
      $display("FAIL boot_rise_latency: got %0d cycles, want %0d", n + 1, SETUP + 1);
    end
    exp_q.push_back(DEF_ID);
    wait_idle(ok);
    n_checks++;
    if (!ok) begin
      n_fail++;
      $display("FAIL boot_busy_fall: busy got 1 after timeout, want 0");
    end
    wb_xfer(1'b0, BASE + 32'h4, 32'h0, 4'hF, rd, w);
    n_checks++;
    if (rd !== 32'd1 || w !== 1) begin
      n_fail++;
      $display("FAIL boot_status: got %h (ack wait %0d), want 00000001 (1)", rd, w);
    end
  endtask

  task automatic test_idle_write;
    logic [31:0] rd;
    int w, n, hi;
    logic ok;
    wb_xfer(1'b1, BASE, 32'h5, 4'h1, rd, w);
    n_checks++;
    if (w !== 1) begin
      n_fail++;
      $display("FAIL write_ack_latency: got %0d, want 1", w);
    end
    cycles_to_rise(n);
    n_checks++;
    if (n !== 1 + SETUP || sel_id !== 4'h5) begin
      n_fail++;
      $display("FAIL launch_latency: got %0d cycles id=%h, want %0d id=5", n, sel_id, 1 + SETUP);
    end
    hi = 1;
    for (int i = 0; i < 20; i++) begin
      @(negedge wb_clk_i);
      if (!sel_clk) break;
      hi++;
    end
    n_checks++;
    if (hi !== HIGH) begin
      n_fail++;
      $display("FAIL high_width: got %0d cycles, want %0d", hi, HIGH);
    end
    exp_q.push_back(4'h5);
    wait_idle(ok);
    wb_xfer(1'b0, BASE, 32'h0, 4'hF, rd, w);
    n_checks++;
    if (rd !== 32'h05 || !ok) begin
      n_fail++;
      $display("FAIL ctrl_read_idle: got %h (idle=%b), want 00000005", rd, ok);
    end
    @(negedge wb_clk_i);
    n_checks++;
    if (bus.wbs_ack_o !== 1'b0 || bus.wbs_dat_o !== 32'h0) begin
      n_fail++;
      $display("FAIL dat_after_ack: got ack=%b dat=%h, want 0 0", bus.wbs_ack_o, bus.wbs_dat_o);
    end
    wb_xfer(1'b0, BASE + 32'h4, 32'h0, 4'hF, rd, w);
    n_checks++;
    if (rd !== 32'd2) begin
      n_fail++;
      $display("FAIL status_after_write: got %h, want 00000002", rd);
    end
  endtask

  task automatic test_back_to_back;
    logic [31:0] rd;
    int w1, w2, w3, start, n;
    logic gap, ok;
    start = cap_q.size();
    wb_xfer(1'b1, BASE, 32'h1, 4'h1, rd, w1);
    wb_xfer(1'b1, BASE, 32'h3, 4'h1, rd, w2);
    wb_xfer(1'b1, BASE, 32'h7, 4'h1, rd, w3);
    n_checks++;
    if (w1 !== 1 || w2 !== 1 || w3 !== 1) begin
      n_fail++;
      $display("FAIL busy_write_ack: got waits %0d %0d %0d, want 1 1 1", w1, w2, w3);
    end
    gap = 1'b0;
    n = 0;
    while (cap_q.size() < start + 2 && n < 60) begin
      @(negedge wb_clk_i);
      n++;
      if (!busy) gap = 1'b1;
    end
    n_checks++;
    if (cap_q.size() !== start + 2 || gap !== 1'b0 || sel_id !== 4'h7) begin
      n_fail++;
      $display("FAIL back_to_back: got captures=%0d gap=%b id=%h, want %0d 0 7",
               cap_q.size() - start, gap, sel_id, 2);
    end
    exp_q.push_back(4'h1);
    exp_q.push_back(4'h7);
    wb_xfer(1'b0, BASE, 32'h0, 4'hF, rd, w1);
    n_checks++;
    if (rd !== 32'h11) begin
      n_fail++;
      $display("FAIL ctrl_read_busy: got %h, want 00000011", rd);
    end
    wait_idle(ok);
    wb_xfer(1'b0, BASE, 32'h0, 4'hF, rd, w1);
    n_checks++;
    if (rd !== 32'h07 || !ok) begin
      n_fail++;
      $display("FAIL ctrl_read_after_b2b: got %h (idle=%b), want 00000007", rd, ok);
    end
    wb_xfer(1'b0, BASE + 32'h4, 32'h0, 4'hF, rd, w1);
    n_checks++;
    if (rd !== 32'd4) begin
      n_fail++;
      $display("FAIL status_after_b2b: got %h, want 00000004", rd);
    end
  endtask

  task automatic test_ignored_access;
    logic [31:0] rd;
    int w, start;
    start = cap_q.size();
    wb_xfer(1'b1, BASE, 32'hC, 4'b1110, rd, w);
    n_checks++;
    if (w !== 1) begin
      n_fail++;
      $display("FAIL sel0_low_ack: got wait %0d, want 1", w);
    end
    repeat (15) @(negedge wb_clk_i);
    n_checks++;
    if (cap_q.size() !== start || busy !== 1'b0 || sel_id !== 4'h7) begin
      n_fail++;
      $display("FAIL sel0_low_ignored: got captures=%0d busy=%b id=%h, want 0 0 7",
               cap_q.size() - start, busy, sel_id);
    end
    wb_xfer(1'b1, BASE + 32'h4, 32'hFFFF, 4'hF, rd, w);
    wb_xfer(1'b0, BASE + 32'h4, 32'h0, 4'hF, rd, w);
    n_checks++;
    if (rd !== 32'd4) begin
      n_fail++;
      $display("FAIL status_write_ignored: got %h, want 00000004", rd);
    end
    wb_xfer(1'b1, BASE + 32'h8, 32'h2, 4'hF, rd, w);
    n_checks++;
    if (w !== -1) begin
      n_fail++;
      $display("FAIL miss_write_no_ack: got ack after %0d, want none", w);
    end
    wb_xfer(1'b0, BASE + 32'h100, 32'h0, 4'hF, rd, w);
    n_checks++;
    if (w !== -1 || cap_q.size() !== start) begin
      n_fail++;
      $display("FAIL miss_read_no_ack: got ack wait %0d captures=%0d, want none 0", w,
               cap_q.size() - start);
    end
  endtask

  task automatic test_reset_mid_high;
    logic [31:0] rd;
    int w, n;
    logic ok;
    wb_xfer(1'b1, BASE, 32'hA, 4'h1, rd, w);
    cycles_to_rise(n);
    exp_q.push_back(4'hA);
    @(negedge wb_clk_i);
    n_checks++;
    if (sel_clk !== 1'b1 || n !== 1 + SETUP) begin
      n_fail++;
      $display("FAIL pre_abort_high: got clk=%b after %0d, want 1 after %0d", sel_clk, n, 1 + SETUP);
    end
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (sel_clk !== 1'b0 || sel_id !== 4'h0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL async_abort: got clk=%b id=%h busy=%b, want 0 0 0", sel_clk, sel_id, busy);
    end
    repeat (2) @(negedge wb_clk_i);
    rst_n = 1'b1;
    @(negedge wb_clk_i);
    cycles_to_rise(n);
    n_checks++;
    if (n !== SETUP || sel_id !== DEF_ID) begin
      n_fail++;
      $display("FAIL reboot: got rise after %0d id=%h, want %0d id=%h", n + 1, sel_id, SETUP + 1, DEF_ID);
    end
    exp_q.push_back(DEF_ID);
    wait_idle(ok);
    wb_xfer(1'b0, BASE + 32'h4, 32'h0, 4'hF, rd, w);
    n_checks++;
    if (rd !== 32'd1 || !ok) begin
      n_fail++;
      $display("FAIL reboot_status: got %h (idle=%b), want 00000001", rd, ok);
    end
    wb_xfer(1'b0, BASE, 32'h0, 4'hF, rd, w);
    n_checks++;
    if (rd !== {28'b0, DEF_ID}) begin
      n_fail++;
      $display("FAIL reboot_ctrl: got %h, want %h", rd, {28'b0, DEF_ID});
    end
  endtask

  task automatic test_scoreboard;
    n_checks++;
    if (cap_q.size() !== exp_q.size() || viol !== 0) begin
      n_fail++;
      $display("FAIL capture_count: got %0d captures (%0d unstable), want %0d (0)",
               cap_q.size(), viol, exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < cap_q.size(); i++) begin
      n_checks++;
      if (cap_q[i] !== exp_q[i]) begin
        n_fail++;
        $display("FAIL capture_%0d: got id %h, want %h", i, cap_q[i], exp_q[i]);
      end
    end
  endtask

  initial begin
    bus.wbs_cyc_i = 1'b0;
    bus.wbs_stb_i = 1'b0;
    bus.wbs_we_i  = 1'b0;
    bus.wbs_sel_i = 4'h0;
    bus.wbs_adr_i = '0;
    bus.wbs_dat_i = '0;
    test_reset();
    test_idle_write();
    test_back_to_back();
    test_ignored_access();
    test_reset_mid_high();
    test_scoreboard();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
